timer_periph: RTL and testbench

Memory-mapped programmable down-counter timer on the data bus of the ARMv4 SoC. Replaces the single 32-bit timer register. Consumes the chip-set's timer write-enable and the core's WriteData, and returns a 32-bit read word to the ReadData mux. Provides prescaled countdown, one-shot or periodic mode, sticky expiry flag and level interrupt output.

---
 rtl/timer_periph.sv | 147 ++++++++++++++
 tb/tb_timer_periph.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_periph.sv
// ---------------------------------------------------------------------------
// timer_periph
//   Memory-mapped programmable down-counter timer for the SoC data bus.
//   It has a prescaler, one-shot or periodic operation, a sticky expiry flag
//   and a level interrupt output.
//
//   Register map (word select addr):
//     0 CTRL   : bit0 EN, bit1 RELOAD (1=periodic), bit2 IE,
//                bits[8+PRESC_W-1:8] PRESC. Other bits read as 0.
//     1 LOAD   : reload value (R/W). A write also loads COUNT.
//     2 COUNT  : current count (read-only).
//     3 STATUS : bit0 EXP, sticky. Writing 1 clears it.
//
//   Ports:
//     clk   - system clock, rising edge
//     rst   - asynchronous, active-high reset
//     we    - write strobe (timer region selected and MemWrite)
//     addr  - word select, DataAdr[3:2]
//     wdata - write data from the core
//     rdata - read data. It is a combinational function of addr.
//     irq   - level interrupt, EXP & IE
// ---------------------------------------------------------------------------
module timer_periph #(
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_LOAD   = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic               en;
  logic               reload;
  logic               ie;
  logic [PRESC_W-1:0] presc;
  logic [WIDTH-1:0]   load;
  logic [WIDTH-1:0]   count;
  logic               exp_flag;
  logic [PRESC_W-1:0] pcnt;

  logic wr_ctrl;
  logic wr_load;
  logic wr_status;
  logic tick;
  logic tick_eff;
  logic expire;

  assign wr_ctrl   = we && (addr == A_CTRL);
  assign wr_load   = we && (addr == A_LOAD);
  assign wr_status = we && (addr == A_STATUS);

  // Raw prescaler terminal count.
  assign tick = en && (pcnt == presc);

  // A tick is discarded in two cases. A LOAD write wins over the decrement.
  // A CTRL write that turns EN off also wins, so the tick never takes effect.
  assign tick_eff = tick && !wr_load && !(wr_ctrl && !wdata[0]);

  // The count leaves 1 on this edge.
  assign expire = tick_eff && (count == ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en       <= 1'b0;
      reload   <= 1'b0;
      ie       <= 1'b0;
      presc    <= '0;
      load     <= '0;
      count    <= '0;
      exp_flag <= 1'b0;
      pcnt     <= '0;
    end else begin
      // Counter. COUNT==0 means idle: there is no decrement and no expiry.
      if (wr_load) begin
        load  <= wdata;
        count <= wdata;
      end else if (tick_eff) begin
        if (count > ONE) begin
          count <= count - ONE;
        end else if (count == ONE) begin
          count <= reload ? load : '0;
        end
      end

      // Prescaler. It restarts on a LOAD write and on an EN 0->1 write.
      // It holds while disabled, and it holds when a CTRL write clears EN.
      if (wr_load) begin
        pcnt <= '0;
      end else if (wr_ctrl && wdata[0] && !en) begin
        pcnt <= '0;
      end else if (wr_ctrl && !wdata[0]) begin
        pcnt <= pcnt;
      end else if (en) begin
        pcnt <= tick ? '0 : pcnt + PRESC_W'(1);
      end

      // Control. A software write wins over the hardware EN clear that
      // happens at a one-shot expiry.
      if (wr_ctrl) begin
        en     <= wdata[0];
        reload <= wdata[1];
        ie     <= wdata[2];
        presc  <= wdata[8 +: PRESC_W];
      end else if (expire && !reload) begin
        en <= 1'b0;
      end

      // Sticky expiry flag. A set on the same edge wins over a W1C clear.
      if (expire) begin
        exp_flag <= 1'b1;
      end else if (wr_status && wdata[0]) begin
        exp_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      A_CTRL: begin
        rdata[0]             = en;
        rdata[1]             = reload;
        rdata[2]             = ie;
        rdata[8 +: PRESC_W]  = presc;
      end
      A_LOAD:   rdata = load;
      A_COUNT:  rdata = count;
      A_STATUS: rdata[0] = exp_flag;
      default:  rdata = '0;
    endcase
  end

  // Both terms are registered, so the AND cannot glitch on bus activity.
  assign irq = exp_flag & ie;

endmodule

// File: tb/tb_timer_periph.sv
module tb_timer_periph;

  logic        clk;
  logic        rst;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int errors = 0;
  int checks = 0;

  timer_periph #(.WIDTH(32), .PRESC_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] val;
    logic        irq;
  } vec_t;

  typedef struct {
    string       name;
    logic [1:0]  raddr;
    logic [31:0] val;
    logic        irq;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, want);
    end
  endtask

  task automatic add(input string nm, input logic w, input logic [1:0] a, input logic [31:0] d,
                     input logic [1:0] ra, input logic [31:0] v, input logic iq);
    vec_t t;
    t.name = nm; t.we = w; t.addr = a; t.wdata = d;
    t.raddr = ra; t.val = v; t.irq = iq;
    vecs.push_back(t);
  endtask

  // Run one bus cycle. The expectation is queued when the stimulus is driven.
  // It is then popped and compared against the read after the edge.
  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clk);
    we = v.we; addr = v.addr; wdata = v.wdata;
    e.name = v.name; e.raddr = v.raddr; e.val = v.val; e.irq = v.irq;
    sb.push_back(e);
    @(posedge clk);
    #1;
    we = 1'b0;
    e = sb.pop_front();
    addr = e.raddr;
    #1;
    check(e.name, rdata, e.val);
    check({e.name, "_irq"}, {31'd0, irq}, {31'd0, e.irq});
    $display("step %-12s we=%0b addr=%0d wdata=0x%08h -> raddr=%0d rdata=0x%08h irq=%0b",
             e.name, v.we, v.addr, v.wdata, e.raddr, rdata, irq);
  endtask

  task automatic idle_read(input string nm, input logic [1:0] ra, input logic [31:0] v, input logic iq);
    vec_t t;
    t.name = nm; t.we = 1'b0; t.addr = ra; t.wdata = 32'd0;
    t.raddr = ra; t.val = v; t.irq = iq;
    step(t);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; addr = 2'd0; wdata = 32'd0;

    // One-shot, LOAD=5, EN+IE, PRESC=0
    add("os_load",   1, 2'd1, 32'd5,     2'd2, 32'd5, 0);
    add("os_en",     1, 2'd0, 32'h005,   2'd2, 32'd5, 0);
    add("os_c4",     0, 2'd0, 32'd0,     2'd2, 32'd4, 0);
    add("os_c3",     0, 2'd0, 32'd0,     2'd2, 32'd3, 0);
    add("os_c2",     0, 2'd0, 32'd0,     2'd2, 32'd2, 0);
    add("os_c1",     0, 2'd0, 32'd0,     2'd2, 32'd1, 0);
    add("os_c0",     0, 2'd0, 32'd0,     2'd2, 32'd0, 1);
    add("os_ctrl",   0, 2'd0, 32'd0,     2'd0, 32'h004, 1);
    add("os_hold",   0, 2'd0, 32'd0,     2'd2, 32'd0, 1);
    add("os_exp",    0, 2'd0, 32'd0,     2'd3, 32'd1, 1);
    // W1C behaviour
    add("w1c_zero",  1, 2'd3, 32'd0,     2'd3, 32'd1, 1);
    add("w1c_one",   1, 2'd3, 32'd1,     2'd3, 32'd0, 0);
    // Prescaled periodic, LOAD=3, EN+RELOAD, PRESC=2
    add("pp_load",   1, 2'd1, 32'd3,     2'd2, 32'd3, 0);
    add("pp_en",     1, 2'd0, 32'h203,   2'd2, 32'd3, 0);
    add("pp_1",      0, 2'd0, 32'd0,     2'd2, 32'd3, 0);
    add("pp_2",      0, 2'd0, 32'd0,     2'd2, 32'd3, 0);
    add("pp_3",      0, 2'd0, 32'd0,     2'd2, 32'd2, 0);
    add("pp_4",      0, 2'd0, 32'd0,     2'd2, 32'd2, 0);
    add("pp_5",      0, 2'd0, 32'd0,     2'd2, 32'd2, 0);
    add("pp_6",      0, 2'd0, 32'd0,     2'd2, 32'd1, 0);
    add("pp_7",      0, 2'd0, 32'd0,     2'd2, 32'd1, 0);
    add("pp_8",      0, 2'd0, 32'd0,     2'd3, 32'd0, 0);
    add("pp_wrap",   0, 2'd0, 32'd0,     2'd2, 32'd3, 0);
    add("pp_exp",    0, 2'd0, 32'd0,     2'd3, 32'd1, 0);
    add("pp_clr",    1, 2'd3, 32'd1,     2'd3, 32'd0, 0);
    add("pp_12",     0, 2'd0, 32'd0,     2'd2, 32'd2, 0);
    add("pp_13",     0, 2'd0, 32'd0,     2'd2, 32'd2, 0);
    add("pp_14",     0, 2'd0, 32'd0,     2'd2, 32'd2, 0);
    add("pp_15",     0, 2'd0, 32'd0,     2'd2, 32'd1, 0);
    add("pp_16",     0, 2'd0, 32'd0,     2'd2, 32'd1, 0);
    add("pp_17",     0, 2'd0, 32'd0,     2'd3, 32'd0, 0);
    add("race_set",  1, 2'd3, 32'd1,     2'd3, 32'd1, 0);
    add("race_cnt",  0, 2'd0, 32'd0,     2'd2, 32'd3, 0);
    add("pp_stop",   1, 2'd0, 32'h000,   2'd0, 32'd0, 0);
    // LOAD write on the tick edge
    add("col_clr",   1, 2'd3, 32'd1,     2'd3, 32'd0, 0);
    add("col_load",  1, 2'd1, 32'd2,     2'd2, 32'd2, 0);
    add("col_en",    1, 2'd0, 32'h001,   2'd2, 32'd2, 0);
    add("col_c1",    0, 2'd0, 32'd0,     2'd2, 32'd1, 0);
    add("col_hit",   1, 2'd1, 32'd10,    2'd2, 32'd10, 0);
    add("col_noexp", 0, 2'd0, 32'd0,     2'd3, 32'd0, 0);
    add("col_c8",    0, 2'd0, 32'd0,     2'd2, 32'd8, 0);
    add("col_stop",  1, 2'd0, 32'h000,   2'd2, 32'd8, 0);
    // COUNT is read-only. LOAD=0 leaves the timer idle.
    add("ro_count",  1, 2'd2, 32'h1234,  2'd2, 32'd8, 0);
    add("idle_load", 1, 2'd1, 32'd0,     2'd2, 32'd0, 0);
    add("idle_en",   1, 2'd0, 32'h001,   2'd2, 32'd0, 0);

    // Reset state, checked while reset is held
    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      check($sformatf("rst_reg%0d", a), rdata, 32'd0);
    end
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) step(vecs[i]);

    // With LOAD=0 and EN=1 for 20 cycles, nothing happens.
    for (int i = 0; i < 20; i++) idle_read("idle_cnt", 2'd2, 32'd0, 0);
    idle_read("idle_exp",  2'd3, 32'd0, 0);
    idle_read("idle_ctrl", 2'd0, 32'h001, 0);

    // Only the defined CTRL bits can be written.
    begin
      vec_t t;
      t.name = "ctrl_mask"; t.we = 1; t.addr = 2'd0; t.wdata = 32'hFFFF_FFF6;
      t.raddr = 2'd0; t.val = 32'h0000_FF06; t.irq = 0;
      step(t);
      t.name = "ctrl_off"; t.wdata = 32'h0; t.val = 32'h0;
      step(t);
    end

    // Reset asserted mid-count takes effect immediately, without a clock edge.
    begin
      vec_t t;
      t.name = "mr_load"; t.we = 1; t.addr = 2'd1; t.wdata = 32'd7;
      t.raddr = 2'd2; t.val = 32'd7; t.irq = 0;
      step(t);
      t.name = "mr_en"; t.addr = 2'd0; t.wdata = 32'h005;
      step(t);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    addr = 2'd2; #1; check("mr_count", rdata, 32'd0);
    addr = 2'd0; #1; check("mr_ctrl",  rdata, 32'd0);
    addr = 2'd3; #1; check("mr_exp",   rdata, 32'd0);
    check("mr_irq", {31'd0, irq}, 32'd0);
    $display("step mid_reset count/ctrl/status/irq sampled before next edge");
    @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
